// File: rtl/lc3_mmio_responder.sv
// lc3_mmio_responder: device-register responder for the LC3 data memory bus.
// It decodes the KBSR/KBDR/DSR/DDR window, captures keyboard characters,
// hands display characters to an external sink, and raises the interrupt
// requests. SEL tells the top level to mux RDATA over the memory read data.
// Optional feature macro: LC3_MCR_EN adds the machine control register at
// MCR_ADDR, which drives CLK_EN. Without the macro, CLK_EN is tied high.
module lc3_mmio_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter logic [15:0] MCR_ADDR  = 16'hFFFE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic        RE,
  input  logic        WE,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        SEL,
  input  logic        KB_VALID,
  input  logic [7:0]  KB_DATA,
  output logic        KB_READY,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_DATA,
  input  logic        DISP_READY,
  output logic        KB_INT,
  output logic        DISP_INT,
  output logic        CLK_EN
);

`ifdef LC3_MCR_EN
  localparam logic MCR_PRESENT = 1'b1;
`else
  localparam logic MCR_PRESENT = 1'b0;
`endif

  // Register state
  logic       kb_rdy;
  logic       kb_ie;
  logic [7:0] kb_data;
  logic       ds_rdy;
  logic       ds_ie;
  logic       disp_valid;
  logic [7:0] disp_data;

  // Address decode
  logic hit_kbsr;
  logic hit_kbdr;
  logic hit_dsr;
  logic hit_ddr;
  logic hit_mcr;
  logic mapped;

  assign hit_kbsr = (ADDR == BASE_ADDR);
  assign hit_kbdr = (ADDR == BASE_ADDR + 16'd2);
  assign hit_dsr  = (ADDR == BASE_ADDR + 16'd4);
  assign hit_ddr  = (ADDR == BASE_ADDR + 16'd6);
  assign hit_mcr  = MCR_PRESENT & (ADDR == MCR_ADDR);
  assign mapped   = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr | hit_mcr;

  assign SEL = (RE | WE) & mapped;

  // Bus events
  logic kb_accept;
  logic kb_read;
  logic disp_write;
  logic disp_done;

  assign kb_accept  = KB_VALID & KB_READY;
  assign kb_read    = RE & hit_kbdr;
  assign disp_write = WE & hit_ddr & ds_rdy;
  assign disp_done  = disp_valid & DISP_READY;

  // Only bits 14, 7:0 (and 15 for the MCR) of store data are meaningful
  logic unused_wdata;
  assign unused_wdata = ^{WDATA[15], WDATA[13:8]};

`ifdef LC3_MCR_EN
  logic run;

  // Machine control run bit: once the core stops itself only RESET restarts it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      run <= 1'b1;
    end else if (WE && hit_mcr) begin
      run <= run & WDATA[15];
    end
  end

  assign CLK_EN = run;
`else
  assign CLK_EN = 1'b1;
`endif

  // Keyboard side: capture a character when empty, drain it on a KBDR read
  always_ff @(posedge CLK) begin
    if (RESET) begin
      kb_rdy  <= 1'b0;
      kb_ie   <= 1'b0;
      kb_data <= 8'h00;
    end else begin
      if (WE && hit_kbsr) begin
        kb_ie <= WDATA[14];
      end
      if (kb_accept) begin
        kb_data <= KB_DATA;
        kb_rdy  <= 1'b1;
      end else if (kb_read) begin
        kb_rdy  <= 1'b0;
      end
    end
  end

  // Display side: a DDR store launches a character that is held until taken
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ds_rdy     <= 1'b1;
      ds_ie      <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      if (WE && hit_dsr) begin
        ds_ie <= WDATA[14];
      end
      if (disp_write) begin
        disp_data  <= WDATA[7:0];
        disp_valid <= 1'b1;
        ds_rdy     <= 1'b0;
      end else if (disp_done) begin
        disp_valid <= 1'b0;
        ds_rdy     <= 1'b1;
      end
    end
  end

  // Read mux: always reflects ADDR, whether or not RE is asserted
  always_comb begin
    RDATA = 16'h0000;
    if (hit_kbsr) begin
      RDATA = {kb_rdy, kb_ie, 14'b0};
    end else if (hit_kbdr) begin
      RDATA = {8'h00, kb_data};
    end else if (hit_dsr) begin
      RDATA = {ds_rdy, ds_ie, 14'b0};
    end else if (hit_ddr) begin
      RDATA = 16'h0000;
`ifdef LC3_MCR_EN
    end else if (hit_mcr) begin
      RDATA = {run, 15'b0};
`endif
    end
  end

  assign KB_READY   = ~kb_rdy;
  assign DISP_VALID = disp_valid;
  assign DISP_DATA  = disp_data;
  assign KB_INT     = kb_rdy & kb_ie;
  assign DISP_INT   = ds_rdy & ds_ie;

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// tb_lc3_mmio_responder: scoreboard bench for lc3_mmio_responder.
// Stimulus pushes expected register/pin values and expected display
// characters into queues; a negedge monitor pops and compares them.
module tb_lc3_mmio_responder;

  logic        CLK;
  logic        RESET;
  logic [15:0] ADDR;
  logic        RE;
  logic        WE;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        SEL;
  logic        KB_VALID;
  logic [7:0]  KB_DATA;
  logic        KB_READY;
  logic        DISP_VALID;
  logic [7:0]  DISP_DATA;
  logic        DISP_READY;
  logic        KB_INT;
  logic        DISP_INT;
  logic        CLK_EN;

  lc3_mmio_responder dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ADDR       (ADDR),
    .RE         (RE),
    .WE         (WE),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .SEL        (SEL),
    .KB_VALID   (KB_VALID),
    .KB_DATA    (KB_DATA),
    .KB_READY   (KB_READY),
    .DISP_VALID (DISP_VALID),
    .DISP_DATA  (DISP_DATA),
    .DISP_READY (DISP_READY),
    .KB_INT     (KB_INT),
    .DISP_INT   (DISP_INT),
    .CLK_EN     (CLK_EN)
  );

  localparam int S_RDATA = 0;
  localparam int S_SEL   = 1;
  localparam int S_KBRDY = 2;
  localparam int S_DVAL  = 3;
  localparam int S_DDATA = 4;
  localparam int S_KBINT = 5;
  localparam int S_DINT  = 6;
  localparam int S_CLKEN = 7;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] disp_q[$];
  int         checks = 0;
  int         errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      S_RDATA: observe = RDATA;
      S_SEL:   observe = {15'b0, SEL};
      S_KBRDY: observe = {15'b0, KB_READY};
      S_DVAL:  observe = {15'b0, DISP_VALID};
      S_DDATA: observe = {8'b0, DISP_DATA};
      S_KBINT: observe = {15'b0, KB_INT};
      S_DINT:  observe = {15'b0, DISP_INT};
      default: observe = {15'b0, CLK_EN};
    endcase
  endfunction

  // Monitor: compare queued expectations and every accepted display character
  always @(negedge CLK) begin : monitor
    exp_t       e;
    logic [7:0] d;
    logic [15:0] got;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    if (DISP_VALID && DISP_READY) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL disp_unexpected: got %h expected none", DISP_DATA);
      end else begin
        d = disp_q.pop_front();
        if (DISP_DATA !== d) begin
          errors++;
          $display("[TB] FAIL disp_char: got %h expected %h", DISP_DATA, d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic re,
                               input logic we, input logic [15:0] wdata);
    ADDR  = addr;
    RE    = re;
    WE    = we;
    WDATA = wdata;
  endtask

  task automatic checkOutput(input int sig, input logic [15:0] exp,
                             input string name);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  initial begin
    RESET      = 1'b1;
    KB_VALID   = 1'b0;
    KB_DATA    = 8'h00;
    DISP_READY = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    RESET = 1'b0;

    // Reset state
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h8000, "rst_dsr");
    checkOutput(S_KBRDY, 16'h0001, "rst_kb_ready");
    checkOutput(S_DVAL,  16'h0000, "rst_disp_valid");
    checkOutput(S_CLKEN, 16'h0001, "rst_clk_en");
    checkOutput(S_SEL,   16'h0000, "rst_sel_idle");
    tick();
    applyStimulus(16'hFE00, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h0000, "rst_kbsr");
    tick();

    // Keyboard capture and drain
    KB_VALID = 1'b1;
    KB_DATA  = 8'h41;
    checkOutput(S_KBRDY, 16'h0001, "kb_ready_empty");
    tick();
    KB_VALID = 1'b0;
    checkOutput(S_RDATA, 16'h8000, "kbsr_full");
    checkOutput(S_KBRDY, 16'h0000, "kb_ready_full");
    checkOutput(S_KBINT, 16'h0000, "kb_int_noie");
    tick();
    applyStimulus(16'hFE02, 1'b1, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h0041, "kbdr_read");
    checkOutput(S_SEL,   16'h0001, "kbdr_sel");
    tick();
    applyStimulus(16'hFE00, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h0000, "kbsr_drained");
    checkOutput(S_KBRDY, 16'h0001, "kb_ready_drained");
    tick();

    // Display handshake with a stalled sink
    applyStimulus(16'hFE06, 1'b0, 1'b1, 16'h0048);
    disp_q.push_back(8'h48);
    checkOutput(S_SEL,   16'h0001, "ddr_sel");
    checkOutput(S_RDATA, 16'h0000, "ddr_reads_zero");
    tick();
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      checkOutput(S_DVAL,  16'h0001, "disp_valid_hold");
      checkOutput(S_DDATA, 16'h0048, "disp_data_hold");
      checkOutput(S_RDATA, 16'h0000, "dsr_busy");
      tick();
    end
    DISP_READY = 1'b1;
    tick();
    DISP_READY = 1'b0;
    checkOutput(S_DVAL,  16'h0000, "disp_valid_done");
    checkOutput(S_RDATA, 16'h8000, "dsr_idle_again");
    tick();

    // Write to DDR while busy is dropped
    applyStimulus(16'hFE06, 1'b0, 1'b1, 16'h0031);
    disp_q.push_back(8'h31);
    tick();
    applyStimulus(16'hFE06, 1'b0, 1'b1, 16'h0032);
    checkOutput(S_DVAL, 16'h0001, "busy_valid");
    tick();
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_DDATA, 16'h0031, "busy_data_kept");
    tick();
    DISP_READY = 1'b1;
    tick();
    DISP_READY = 1'b0;
    tick();

    // Keyboard interrupt enable; only bit 14 is writable
    applyStimulus(16'hFE00, 1'b0, 1'b1, 16'hFFFF);
    tick();
    applyStimulus(16'hFE00, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h4000, "kbsr_ie_only");
    checkOutput(S_KBINT, 16'h0000, "kb_int_empty");
    KB_VALID = 1'b1;
    KB_DATA  = 8'h5A;
    tick();
    KB_VALID = 1'b0;
    checkOutput(S_KBINT, 16'h0001, "kb_int_set");
    checkOutput(S_RDATA, 16'hC000, "kbsr_ie_full");
    tick();
    applyStimulus(16'hFE02, 1'b1, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h005A, "kbdr_read2");
    tick();
    applyStimulus(16'hFE00, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_KBINT, 16'h0000, "kb_int_cleared");
    checkOutput(S_RDATA, 16'h4000, "kbsr_ie_kept");
    tick();

    // RE and WE together on KBDR: read drains, write ignored
    KB_VALID = 1'b1;
    KB_DATA  = 8'h33;
    tick();
    KB_VALID = 1'b0;
    applyStimulus(16'hFE02, 1'b1, 1'b1, 16'h00FF);
    checkOutput(S_RDATA, 16'h0033, "kbdr_rw_read");
    tick();
    applyStimulus(16'hFE02, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_RDATA, 16'h0033, "kbdr_write_ignored");
    checkOutput(S_KBRDY, 16'h0001, "kb_ready_after_rw");
    tick();

    // Display interrupt enable
    applyStimulus(16'hFE04, 1'b0, 1'b1, 16'h4000);
    tick();
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_DINT,  16'h0001, "disp_int_set");
    checkOutput(S_RDATA, 16'hC000, "dsr_ie_idle");
    tick();
    applyStimulus(16'hFE06, 1'b0, 1'b1, 16'h0021);
    disp_q.push_back(8'h21);
    tick();
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_DINT, 16'h0000, "disp_int_busy");
    checkOutput(S_DVAL, 16'h0001, "disp_valid_21");
    DISP_READY = 1'b1;
    tick();
    DISP_READY = 1'b0;
    checkOutput(S_DINT, 16'h0001, "disp_int_back");
    tick();

    // Unmapped and MCR addresses
    applyStimulus(16'hFE08, 1'b1, 1'b0, 16'h0000);
    checkOutput(S_SEL,   16'h0000, "unmapped_sel");
    checkOutput(S_RDATA, 16'h0000, "unmapped_rdata");
    tick();
`ifdef LC3_MCR_EN
    applyStimulus(16'hFFFE, 1'b1, 1'b0, 16'h0000);
    checkOutput(S_SEL,   16'h0001, "mcr_sel");
    checkOutput(S_RDATA, 16'h8000, "mcr_run");
    tick();
    applyStimulus(16'hFFFE, 1'b0, 1'b1, 16'h0000);
    tick();
    applyStimulus(16'hFFFE, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_CLKEN, 16'h0000, "mcr_stopped");
    checkOutput(S_RDATA, 16'h0000, "mcr_read_stopped");
    tick();
    applyStimulus(16'hFFFE, 1'b0, 1'b1, 16'h8000);
    tick();
    applyStimulus(16'hFFFE, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_CLKEN, 16'h0000, "mcr_sticky");
    tick();
`else
    applyStimulus(16'hFFFE, 1'b1, 1'b1, 16'h0000);
    checkOutput(S_SEL,   16'h0000, "mcr_unmapped_sel");
    checkOutput(S_RDATA, 16'h0000, "mcr_unmapped_rdata");
    tick();
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_CLKEN, 16'h0001, "clk_en_tied");
    tick();
`endif

    // Reset in the middle of a display transfer
    applyStimulus(16'hFE06, 1'b0, 1'b1, 16'h0077);
    tick();
    applyStimulus(16'hFE04, 1'b0, 1'b0, 16'h0000);
    checkOutput(S_DVAL,  16'h0001, "pre_reset_valid");
    checkOutput(S_DDATA, 16'h0077, "pre_reset_data");
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkOutput(S_DVAL,  16'h0000, "reset_drops_valid");
    checkOutput(S_DDATA, 16'h0000, "reset_clears_data");
    checkOutput(S_RDATA, 16'h8000, "reset_dsr");
    checkOutput(S_DINT,  16'h0000, "reset_disp_int");
    checkOutput(S_CLKEN, 16'h0001, "reset_clk_en");
    tick();
    DISP_READY = 1'b1;
    checkOutput(S_DVAL, 16'h0000, "no_stale_char");
    tick();
    DISP_READY = 1'b0;
    @(negedge CLK);
    #1;

    checks++;
    if (disp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL disp_drain: got %0d pending expected 0", disp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
